axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-requester arbiter sharing the single AXI4 read port to memory between the instruction cache refill path (requester 0) and the data cache/LSU read path (requester 1). It sits between the fetch-stage icache and the LSU on one side and the memory/crossbar read channel on the other. It keeps one transaction outstanding at a time, including full bursts, and routes the R beats back to the granted requester. On ties it uses round-robin, so neither fetch nor loads can starve.

## Interface
- ADDR_W, 32, AR address width
- DATA_W, 64, R data width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- s0_araddr / s1_araddr  in  ADDR_W  requester read address
- s0_arvalid / s1_arvalid  in  1  requester address valid
- s0_arburst / s1_arburst  in  2  burst type
- s0_arlen / s1_arlen  in  8  beats minus one
- s0_arsize / s1_arsize  in  3  bytes per beat, log2
- s0_arready / s1_arready  out  1  address accepted
- s0_rdata / s1_rdata  out  DATA_W  read data
- s0_rresp / s1_rresp  out  2  read response
- s0_rvalid / s1_rvalid  out  1  beat valid
- s0_rlast / s1_rlast  out  1  final beat
- s0_rready / s1_rready  in  1  requester accepts beat
- m_araddr, m_arvalid, m_arburst, m_arlen, m_arsize  out  ADDR_W/1/2/8/3  memory AR channel
- m_arready  in  1
- m_rdata, m_rresp, m_rvalid, m_rlast  in  DATA_W/2/1/1  memory R channel
- m_rready  out  1
- grant  out  1  index of the owning requester; valid while busy
- busy  out  1  state is not IDLE
- len_err  out  1  one-cycle pulse when m_rlast does not match the latched beat count

## Operation
- States:
  - IDLE: no owner.
  - ADDR: AR channel is forwarded from the owner.
  - DATA: R channel is routed to the owner.
- IDLE:
  - If either arvalid is high, pick an owner, register it in grant, and go to ADDR.
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not last_owner wins.
- ADDR:
  - m_ar* carries the owner's ar* fields combinationally.
  - m_arvalid equals the owner's arvalid.
  - The owner's arready equals m_arready. The non-owner's arready is 0.
  - On m_arvalid & m_arready: latch arlen into beat_left, then go to DATA.
  - If the owner drops arvalid before the handshake, go back to IDLE. No transfer occurs and last_owner is unchanged.
- DATA:
  - The owner's r* outputs carry m_r*. m_rready equals the owner's rready.
  - The non-owner sees rvalid=0, rlast=0, rdata=0, rresp=0.
  - On each beat handshake, beat_left decrements.
  - A handshake with m_rlast=1 ends the transaction: go to IDLE and set last_owner=grant.
- len_err: pulses on a handshake where m_rlast differs from (beat_left==0).
  - If m_rlast=1, the transaction still ends.
  - If m_rlast=0 and beat_left==0, stay in DATA until rlast arrives; beat_left holds at 0.
- rresp (SLVERR/DECERR) is passed through unchanged. The arbiter does not act on it.
- In IDLE, every requester-facing output and every m_* output is 0.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_owner=1 (requester 0 wins the first tie), beat_left=0.
  - All outputs 0.
- Reset asserted mid-transaction: state goes to IDLE immediately, regardless of the clock. The in-flight burst is abandoned.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N drives m_arvalid=1 in cycle N+1.
- Minimum single-beat transaction: 3 cycles (IDLE, ADDR, DATA), assuming m_arready is high on entry and the beat arrives immediately.
- Re-arbitration: the IDLE cycle after rlast is mandatory, so back-to-back transactions are separated by at least 1 cycle.
- A requester whose arvalid rises while the other owns the port waits. Its arready stays 0 until it is granted.
- m_arvalid never rises in the same cycle that the grant changes.

## Structure
- A shared package holds:
  - the state encoding (IDLE=0, ADDR=1, DATA=2);
  - the AXI burst, size and resp constants;
  - ADDR_W and DATA_W defaults, reused by the icache and the LSU.
- Sub-module rr_pick2 is combinational: inputs req[1:0] and last_owner, output winner.
- The top level contains the FSM, the beat counter and the channel muxes.

## Test plan
- Single icache request:
  - Stimulus: s0 araddr=0x80000000, arlen=3, arburst=INCR. Memory returns 4 beats with rlast on the 4th.
  - Expected: s0 receives 4 beats. busy falls the cycle after the last beat. len_err stays 0.
- Simultaneous requests from reset:
  - Stimulus: s0 and s1 both assert arvalid.
  - Expected: s0 is served first. s1 then gets arready only after s0's rlast plus the IDLE cycle.
- Repeated contention:
  - Stimulus: both requesters hold arvalid continuously for 4 single-beat transactions.
  - Expected: grant sequence is 0, 1, 0, 1.
- Slow slave:
  - Stimulus: m_arready held low for 5 cycles; rready toggled with 2-cycle bubbles.
  - Expected: the AR fields stay stable. No beat is lost or duplicated. The non-owner's rvalid stays 0.
- Burst length mismatch:
  - Stimulus: arlen=1, but memory asserts rlast on the 1st beat.
  - Expected: len_err pulses for 1 cycle and state returns to IDLE. In a second case with arlen=0 and rlast on the 2nd beat, len_err pulses on beat 1 and the transaction completes on beat 2.
- Async reset mid-burst:
  - Stimulus: assert rst between beats 2 and 3 of a 4-beat burst.
  - Expected: busy, m_rready and s*_rvalid go to 0 immediately. After release, a new s1 request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI4 read-port arbiter: FSM encoding, AXI field constants
// and the default bus widths also used by the icache and the LSU.
package axi_rd_arbiter_pkg;

  parameter int unsigned DefAddrW = 32;
  parameter int unsigned DefDataW = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } arb_state_e;

  localparam logic [1:0] AxiBurstFixed = 2'b00;
  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiBurstWrap  = 2'b10;

  localparam logic [2:0] AxiSize1B = 3'd0;
  localparam logic [2:0] AxiSize2B = 3'd1;
  localparam logic [2:0] AxiSize4B = 3'd2;
  localparam logic [2:0] AxiSize8B = 3'd3;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespExOkay = 2'b01;
  localparam logic [1:0] AxiRespSlvErr = 2'b10;
  localparam logic [1:0] AxiRespDecErr = 2'b11;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one that
// did not own the port last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~last_owner;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between icache refill (requester 0) and LSU reads (requester 1),
// one transaction at a time, routing R beats back to the owner.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic              s0_arvalid,
  input  logic [1:0]        s0_arburst,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rvalid,
  output logic              s0_rlast,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic              s1_arvalid,
  input  logic [1:0]        s1_arburst,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rvalid,
  output logic              s1_rlast,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  output logic [1:0]        m_arburst,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              grant,
  output logic              busy,
  output logic              len_err
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] beat_left_q, beat_left_d;
  logic       winner;
  logic       own_arvalid;
  logic       own_rready;

  rr_pick2 u_pick (
    .req        ({s1_arvalid, s0_arvalid}),
    .last_owner (last_owner_q),
    .winner     (winner)
  );

  assign own_arvalid = grant_q ? s1_arvalid : s0_arvalid;
  assign own_rready  = grant_q ? s1_rready : s0_rready;
  assign grant       = grant_q;
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_owner_q <= 1'b1;
      beat_left_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      beat_left_q  <= beat_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    beat_left_d  = beat_left_q;
    len_err      = 1'b0;
    m_araddr     = '0;
    m_arvalid    = 1'b0;
    m_arburst    = 2'b00;
    m_arlen      = 8'd0;
    m_arsize     = 3'd0;
    m_rready     = 1'b0;
    s0_arready   = 1'b0;
    s0_rdata     = '0;
    s0_rresp     = 2'b00;
    s0_rvalid    = 1'b0;
    s0_rlast     = 1'b0;
    s1_arready   = 1'b0;
    s1_rdata     = '0;
    s1_rresp     = 2'b00;
    s1_rvalid    = 1'b0;
    s1_rlast     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s0_arvalid || s1_arvalid) begin
          grant_d = winner;
          state_d = StAddr;
        end
      end
      StAddr: begin
        m_araddr  = grant_q ? s1_araddr : s0_araddr;
        m_arburst = grant_q ? s1_arburst : s0_arburst;
        m_arlen   = grant_q ? s1_arlen : s0_arlen;
        m_arsize  = grant_q ? s1_arsize : s0_arsize;
        m_arvalid = own_arvalid;
        if (grant_q) begin
          s1_arready = m_arready;
        end else begin
          s0_arready = m_arready;
        end
        if (own_arvalid && m_arready) begin
          beat_left_d = grant_q ? s1_arlen : s0_arlen;
          state_d     = StData;
        end else if (!own_arvalid) begin
          // Owner withdrew before the handshake: nothing transferred, fairness untouched.
          state_d = StIdle;
        end
      end
      StData: begin
        m_rready = own_rready;
        if (grant_q) begin
          s1_rdata  = m_rdata;
          s1_rresp  = m_rresp;
          s1_rvalid = m_rvalid;
          s1_rlast  = m_rlast;
        end else begin
          s0_rdata  = m_rdata;
          s0_rresp  = m_rresp;
          s0_rvalid = m_rvalid;
          s0_rlast  = m_rlast;
        end
        if (m_rvalid && own_rready) begin
          len_err = (m_rlast != (beat_left_q == 8'd0));
          if (m_rlast) begin
            state_d      = StIdle;
            last_owner_d = grant_q;
          end else if (beat_left_q != 8'd0) begin
            beat_left_d = beat_left_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] s0_araddr, s1_araddr;
  logic        s0_arvalid, s1_arvalid;
  logic [1:0]  s0_arburst, s1_arburst;
  logic [7:0]  s0_arlen, s1_arlen;
  logic [2:0]  s0_arsize, s1_arsize;
  logic        s0_arready, s1_arready;
  logic [63:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rlast, s1_rlast;
  logic        s0_rready, s1_rready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic [1:0]  m_arburst;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic        m_arready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
  logic        grant;
  logic        busy;
  logic        len_err;

  int n_cmp = 0;
  int n_fail = 0;

  axi_rd_arbiter #(
    .ADDR_W (32),
    .DATA_W (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s0_araddr  (s0_araddr),
    .s0_arvalid (s0_arvalid),
    .s0_arburst (s0_arburst),
    .s0_arlen   (s0_arlen),
    .s0_arsize  (s0_arsize),
    .s0_arready (s0_arready),
    .s0_rdata   (s0_rdata),
    .s0_rresp   (s0_rresp),
    .s0_rvalid  (s0_rvalid),
    .s0_rlast   (s0_rlast),
    .s0_rready  (s0_rready),
    .s1_araddr  (s1_araddr),
    .s1_arvalid (s1_arvalid),
    .s1_arburst (s1_arburst),
    .s1_arlen   (s1_arlen),
    .s1_arsize  (s1_arsize),
    .s1_arready (s1_arready),
    .s1_rdata   (s1_rdata),
    .s1_rresp   (s1_rresp),
    .s1_rvalid  (s1_rvalid),
    .s1_rlast   (s1_rlast),
    .s1_rready  (s1_rready),
    .m_araddr   (m_araddr),
    .m_arvalid  (m_arvalid),
    .m_arburst  (m_arburst),
    .m_arlen    (m_arlen),
    .m_arsize   (m_arsize),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rlast    (m_rlast),
    .m_rready   (m_rready),
    .grant      (grant),
    .busy       (busy),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int b;
    logic exp_grant [4];
    exp_grant[0] = 1'b0; exp_grant[1] = 1'b1; exp_grant[2] = 1'b0; exp_grant[3] = 1'b1;

    rst = 1'b1;
    s0_araddr = '0; s0_arvalid = 0; s0_arburst = AxiBurstIncr; s0_arlen = 0;
    s0_arsize = AxiSize8B; s0_rready = 1;
    s1_araddr = '0; s1_arvalid = 0; s1_arburst = AxiBurstIncr; s1_arlen = 0;
    s1_arsize = AxiSize8B; s1_rready = 1;
    m_arready = 1; m_rdata = '0; m_rresp = AxiRespOkay; m_rvalid = 0; m_rlast = 0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_len_err", len_err, 0);
    tick();
    rst = 1'b0;

    // Single icache 4-beat INCR burst
    s0_araddr = 32'h8000_0000; s0_arlen = 8'd3; s0_arvalid = 1;
    #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_m_arvalid", m_arvalid, 0);
    tick();
    #1;
    chk("t1_addr_busy", busy, 1);
    chk("t1_addr_grant", grant, 0);
    chk("t1_m_arvalid", m_arvalid, 1);
    chk("t1_m_araddr", m_araddr, 32'h8000_0000);
    chk("t1_m_arlen", m_arlen, 3);
    chk("t1_m_arburst", m_arburst, AxiBurstIncr);
    chk("t1_s0_arready", s0_arready, 1);
    chk("t1_s1_arready", s1_arready, 0);
    tick();
    s0_arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1; m_rdata = 64'h100 + 64'(i); m_rlast = (i == 3);
      m_rresp = (i == 1) ? AxiRespSlvErr : AxiRespOkay;
      #1;
      chk("t1_s0_rvalid", s0_rvalid, 1);
      chk("t1_s0_rdata", s0_rdata, 64'h100 + 64'(i));
      chk("t1_s0_rresp", s0_rresp, (i == 1) ? AxiRespSlvErr : AxiRespOkay);
      chk("t1_s0_rlast", s0_rlast, (i == 3));
      chk("t1_s1_rvalid", s1_rvalid, 0);
      chk("t1_m_rready", m_rready, 1);
      chk("t1_len_err", len_err, 0);
      tick();
    end
    m_rvalid = 0; m_rlast = 0; m_rresp = AxiRespOkay;
    #1;
    chk("t1_busy_after", busy, 0);

    // Simultaneous requests out of reset: s0 first, s1 after rlast + IDLE
    rst = 1; #1; rst = 0;
    s0_araddr = 32'h0000_0400; s0_arlen = 0; s0_arvalid = 1;
    s1_araddr = 32'h0000_0800; s1_arlen = 0; s1_arvalid = 1;
    tick();
    #1;
    chk("t2_grant0", grant, 0);
    chk("t2_m_araddr0", m_araddr, 32'h0000_0400);
    chk("t2_s0_arready", s0_arready, 1);
    chk("t2_s1_arready_a", s1_arready, 0);
    tick();
    s0_arvalid = 0;
    m_rvalid = 1; m_rdata = 64'hAAAA; m_rlast = 1;
    #1;
    chk("t2_s0_rvalid", s0_rvalid, 1);
    chk("t2_s1_rvalid_a", s1_rvalid, 0);
    chk("t2_s1_arready_b", s1_arready, 0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_s1_arready", s1_arready, 0);
    tick();
    #1;
    chk("t2_grant1", grant, 1);
    chk("t2_m_araddr1", m_araddr, 32'h0000_0800);
    chk("t2_s1_arready_c", s1_arready, 1);
    tick();
    s1_arvalid = 0;
    m_rvalid = 1; m_rdata = 64'hBBBB; m_rlast = 1;
    #1;
    chk("t2_s1_rdata", s1_rdata, 64'hBBBB);
    chk("t2_s0_rvalid_b", s0_rvalid, 0);
    tick();
    m_rvalid = 0; m_rlast = 0;

    // Continuous contention: grants alternate 0,1,0,1
    s0_arvalid = 1; s1_arvalid = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("t3_grant", grant, exp_grant[k]);
      tick();
      m_rvalid = 1; m_rlast = 1; m_rdata = 64'(k);
      #1;
      chk("t3_owner_rvalid", exp_grant[k] ? s1_rvalid : s0_rvalid, 1);
      chk("t3_other_rvalid", exp_grant[k] ? s0_rvalid : s1_rvalid, 0);
      tick();
      m_rvalid = 0; m_rlast = 0;
    end
    s0_arvalid = 0; s1_arvalid = 0;

    // Slow slave: AR stalls 5 cycles, rready with 2-cycle bubbles, s1 waiting
    s0_araddr = 32'h0000_1000; s0_arlen = 2; s0_arvalid = 1;
    s1_araddr = 32'h0000_2000; s1_arlen = 0; s1_arvalid = 1;
    m_arready = 0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_m_arvalid", m_arvalid, 1);
      chk("t4_m_araddr", m_araddr, 32'h0000_1000);
      chk("t4_m_arlen", m_arlen, 2);
      chk("t4_s0_arready", s0_arready, 0);
      chk("t4_s1_arready", s1_arready, 0);
      tick();
    end
    m_arready = 1;
    #1;
    chk("t4_s0_arready_hs", s0_arready, 1);
    tick();
    s0_arvalid = 0;
    b = 0;
    for (int c = 0; c < 20 && b < 3; c++) begin
      s0_rready = (c % 3 == 2);
      m_rvalid = 1; m_rdata = 64'hA0 + 64'(b); m_rlast = (b == 2);
      #1;
      chk("t4_s1_rvalid", s1_rvalid, 0);
      chk("t4_s1_arready_d", s1_arready, 0);
      chk("t4_m_rready", m_rready, s0_rready);
      chk("t4_s0_rdata", s0_rdata, 64'hA0 + 64'(b));
      if (m_rready) b++;
      tick();
    end
    chk("t4_beats", 64'(b), 3);
    m_rvalid = 0; m_rlast = 0; s0_rready = 1;
    #1;
    chk("t4_busy_after", busy, 0);
    tick();
    #1;
    chk("t4_s1_grant", grant, 1);
    chk("t4_s1_araddr", m_araddr, 32'h0000_2000);
    tick();
    s1_arvalid = 0;
    m_rvalid = 1; m_rlast = 1; m_rdata = 64'h5;
    #1;
    chk("t4_s1_rvalid_own", s1_rvalid, 1);
    tick();
    m_rvalid = 0; m_rlast = 0;

    // Length mismatch: early rlast ends transaction
    s0_arlen = 1; s0_arvalid = 1;
    tick();
    tick();
    s0_arvalid = 0;
    m_rvalid = 1; m_rlast = 1;
    #1;
    chk("t5a_len_err", len_err, 1);
    chk("t5a_s0_rlast", s0_rlast, 1);
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t5a_busy", busy, 0);
    chk("t5a_len_err_low", len_err, 0);

    // Length mismatch: late rlast, error on beat 1, completes on beat 2
    s0_arlen = 0; s0_arvalid = 1;
    tick();
    tick();
    s0_arvalid = 0;
    m_rvalid = 1; m_rlast = 0;
    #1;
    chk("t5b_len_err_b1", len_err, 1);
    tick();
    m_rvalid = 0;
    #1;
    chk("t5b_len_err_gap", len_err, 0);
    chk("t5b_busy_gap", busy, 1);
    tick();
    m_rvalid = 1; m_rlast = 1;
    #1;
    chk("t5b_len_err_b2", len_err, 0);
    chk("t5b_s0_rvalid_b2", s0_rvalid, 1);
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t5b_busy", busy, 0);

    // Async reset between beats 2 and 3 of a 4-beat burst
    s0_arlen = 3; s0_arvalid = 1;
    tick();
    tick();
    s0_arvalid = 0;
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1; m_rlast = 0;
      tick();
    end
    m_rvalid = 1;
    #1;
    chk("t6_busy_pre", busy, 1);
    chk("t6_s0_rvalid_pre", s0_rvalid, 1);
    rst = 1;
    #1;
    chk("t6_busy_rst", busy, 0);
    chk("t6_m_rready_rst", m_rready, 0);
    chk("t6_s0_rvalid_rst", s0_rvalid, 0);
    chk("t6_s1_rvalid_rst", s1_rvalid, 0);
    m_rvalid = 0;
    tick();
    rst = 0;
    s1_araddr = 32'h0000_3000; s1_arlen = 0; s1_arvalid = 1;
    tick();
    #1;
    chk("t6_grant", grant, 1);
    chk("t6_m_arvalid", m_arvalid, 1);
    chk("t6_m_araddr", m_araddr, 32'h0000_3000);
    chk("t6_s1_arready", s1_arready, 1);
    tick();
    s1_arvalid = 0;
    m_rvalid = 1; m_rlast = 1; m_rdata = 64'hC0DE;
    #1;
    chk("t6_s1_rdata", s1_rdata, 64'hC0DE);
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t6_busy_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
